cross_bar_req_arb: RTL and testbench
====================================

Name: cross_bar_req_arb

Overview:
- Request-side scheduler of the crossbar, one instance for the whole crossbar.
- Arbitrates 4 channel read requests onto 4 cache banks using per-bank round-robin.
- Allocates the per-(channel,bank) ROB tag (rob_num) that banks echo back with return data.
- Issues the keep-order kickoff to each channel's return ROB.
- Enforces ROB-slot and keep-order-FIFO credits, so return-side buffers can never overflow.

Parameters:
- AW, 32, request address width per channel.
- ROB_DEPTH, 8, sparse-write-buffer slots per (channel,bank); rob_num width is fixed at 3.
- KOF_DEPTH, 16, keep-order FIFO entries per channel.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- ch_req_valid_i  in  4  read request valid; bit c = channel c.
- ch_req_bank_id_i  in  8  target bank; bits [2c+1:2c] for channel c.
- ch_req_addr_i  in  4*AW  request address; slice c.
- ch_req_ready_o  out  4  request accepted (granted) this cycle.
- bank_req_valid_o  out  4  registered request valid toward bank b.
- bank_req_ready_i  in  4  bank b accepts.
- bank_req_ch_id_o  out  8  originating channel, slice b.
- bank_req_rob_num_o  out  12  allocated ROB tag, 3 bits per bank.
- bank_req_addr_o  out  4*AW  address, slice b.
- ch_kickoff_o  out  4  keep-order push to the channel c ROB.
- ch_kickoff_bank_id_o  out  8  bank id pushed with the kickoff.
- ch_bank_pop_i  in  16  ROB slot released; bit 4c+b.
- credit_err_o  out  1  sticky credit underflow flag (see Optional Feature).

Behaviour:
- Reset values:
  - All outputs 0.
  - Round-robin pointers 0.
  - rob_num allocation counters 0.
  - Outstanding counters 0.
  - Output stage registers empty.
- Per-bank output stage:
  - One register per bank.
  - "Free" = empty, or valid and bank_req_ready_i high in the same cycle.
  - Holds ch_id, rob_num and addr stable while valid and not ready.
- Eligibility: channel c is eligible for bank b when all of the following hold:
  - ch_req_valid_i[c] is high.
  - bank_id[c] equals b.
  - outst[c][b] < ROB_DEPTH.
  - kof_cnt[c] < KOF_DEPTH.
  - Output stage b is free.
- Arbitration:
  - Each bank independently grants one eligible channel, round-robin starting from ptr[b].
  - On a grant, ptr[b] <= granted channel + 1 (mod 4).
  - With no grant, ptr[b] is held.
  - A channel targets only one bank per cycle, so it receives at most one grant per cycle.
- Grant cycle (combinational, all in the same cycle):
  - ch_req_ready_o[c] = 1.
  - ch_kickoff_o[c] = 1, with ch_kickoff_bank_id_o slice c = b.
- Cycle after grant:
  - bank_req_valid_o[b] = 1, carrying ch_id = c, rob_num = alloc[c][b] and the granted address.
  - Latency from grant to bank valid is 1 cycle.
  - Back-to-back grants to the same bank are allowed when the bank is ready every cycle.
- Tag allocation:
  - alloc[c][b] is 3 bits and increments on each grant.
  - Wraps 7 -> 0.
  - Matches the sequential read pointer in the channel ROB.
- Credits:
  - outst[c][b] (0..8): +1 on grant, -1 on ch_bank_pop_i[4c+b]; unchanged if both occur in the same cycle.
  - kof_cnt[c] (0..16): +1 on grant, -1 on any pop bit of channel c.
  - At most one pop per channel per cycle is guaranteed by the ROB.
  - At full credit the request stalls with ready low and no kickoff; a pop in the same cycle does not unblock the grant until the next cycle.
- Reset mid-operation: all state is cleared immediately; pending output-stage requests are dropped.

Optional Feature:
- Macro: XBAR_ARB_CREDIT_CHK_EN.
- With the macro defined:
  - credit_err_o goes to 1 the cycle after a pop arrives while outst[c][b] == 0.
  - It also goes to 1 on any grant attempt that would overflow a counter.
  - It stays set until reset.
  - In either error case the counter saturates instead of wrapping.
- Without the macro: credit_err_o is tied to 0, no check logic is built, and counters are plain up/down.

Test Plan:
- Single request: ch1 requests bank2 at addr 0x100 -> ch_req_ready_o=4'b0010 and ch_kickoff_o[1]=1 with bank id 2; next cycle bank_req_valid_o[2]=1, ch_id=1, rob_num=0, addr=0x100.
- Contention: all 4 channels hold requests to bank0 with bank ready -> grants go ch0, ch1, ch2, ch3, ch0 in consecutive cycles, and rob_num of each channel increments independently.
- ROB credit:
  - ch0 issues 8 grants to bank3 with no pops -> 9th request is held with ready=0.
  - Pop bit 3 asserted -> grant happens the following cycle with rob_num=0 (wrap).
- Bank backpressure: bank1 ready=0 for 5 cycles with ch2 valid -> output stage holds its fields stable; exactly one more grant follows, and only once ready returns.
- Parallel banks: ch0->b0, ch1->b1, ch2->b2, ch3->b3 in the same cycle -> all four granted, ch_req_ready_o=4'hF, 4 kickoffs.
- With XBAR_ARB_CREDIT_CHK_EN: pop bit 5 asserted with zero outstanding -> credit_err_o=1 next cycle and it stays set; async reset clears it.

Source files
------------

// File: rtl/cross_bar_req_arb.sv
// Crossbar request scheduler: per-bank round-robin, ROB tag allocation, keep-order kickoff, credits.
// Optional macro XBAR_ARB_CREDIT_CHK_EN builds the sticky credit-error check with saturating counters.
module cross_bar_req_arb #(
   parameter int AW        = 32,
   parameter int ROB_DEPTH = 8,
   parameter int KOF_DEPTH = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [3:0]        ch_req_valid_i,
   input  logic [7:0]        ch_req_bank_id_i,
   input  logic [4*AW-1:0]   ch_req_addr_i,
   output logic [3:0]        ch_req_ready_o,
   output logic [3:0]        bank_req_valid_o,
   input  logic [3:0]        bank_req_ready_i,
   output logic [7:0]        bank_req_ch_id_o,
   output logic [11:0]       bank_req_rob_num_o,
   output logic [4*AW-1:0]   bank_req_addr_o,
   output logic [3:0]        ch_kickoff_o,
   output logic [7:0]        ch_kickoff_bank_id_o,
   input  logic [15:0]       ch_bank_pop_i,
   output logic              credit_err_o
);
   localparam int NCH = 4;
   localparam int NBK = 4;

   logic [3:0]    free_s;
   logic [3:0]    elig_s    [NBK];
   logic [3:0]    gnt_s     [NBK];
   logic [1:0]    gnt_ch_s  [NBK];
   logic [3:0]    ch_gnt_s;

   logic [1:0]    ptr_q     [NBK];
   logic [1:0]    ptr_d     [NBK];
   logic [2:0]    alloc_q   [NCH][NBK];
   logic [2:0]    alloc_d   [NCH][NBK];
   logic [3:0]    outst_q   [NCH][NBK];
   logic [3:0]    outst_d   [NCH][NBK];
   logic [4:0]    kof_q     [NCH];
   logic [4:0]    kof_d     [NCH];
   logic [3:0]    vld_q;
   logic [3:0]    vld_d;
   logic [1:0]    ch_q      [NBK];
   logic [1:0]    ch_d      [NBK];
   logic [2:0]    rob_q     [NBK];
   logic [2:0]    rob_d     [NBK];
   logic [AW-1:0] addr_q    [NBK];
   logic [AW-1:0] addr_d    [NBK];
   logic          err_q;
   logic          err_d;

   // First requester at or after ptr, found by rotating the request vector down and back up.
   function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [7:0] dbl;
      logic [3:0] rot;
      logic [3:0] oh;
      logic [7:0] back;
      dbl  = {req, req} >> ptr;
      rot  = dbl[3:0];
      oh   = rot & (~rot + 4'd1);
      back = {oh, oh} << ptr;
      return back[7:4];
   endfunction

   function automatic logic [1:0] enc4(input logic [3:0] oh);
      logic [1:0] idx;
      case (oh)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   assign free_s = ~vld_q | bank_req_ready_i;

   // Eligibility and per-bank round-robin grant
   always_comb begin
      ch_gnt_s = 4'b0000;
      for (int b = 0; b < NBK; b++) begin
         for (int c = 0; c < NCH; c++) begin
            elig_s[b][c] = ch_req_valid_i[c]
                         && (ch_req_bank_id_i[2*c +: 2] == 2'(b))
                         && (outst_q[c][b] < 4'(ROB_DEPTH))
                         && (kof_q[c] < 5'(KOF_DEPTH))
                         && free_s[b];
         end
         gnt_s[b]    = rr_pick(elig_s[b], ptr_q[b]);
         gnt_ch_s[b] = enc4(gnt_s[b]);
         ch_gnt_s    = ch_gnt_s | gnt_s[b];
      end
   end

   // Grant-cycle handshake and kickoff toward the channel ROBs
   always_comb begin
      ch_req_ready_o       = ch_gnt_s;
      ch_kickoff_o         = ch_gnt_s;
      ch_kickoff_bank_id_o = 8'h00;
      for (int c = 0; c < NCH; c++) begin
         if (ch_gnt_s[c]) begin
            ch_kickoff_bank_id_o[2*c +: 2] = ch_req_bank_id_i[2*c +: 2];
         end else begin
            ch_kickoff_bank_id_o[2*c +: 2] = 2'b00;
         end
      end
   end

   // Output stage, pointer and tag next state
   always_comb begin
      for (int b = 0; b < NBK; b++) begin
         if (gnt_s[b] != 4'b0000) begin
            vld_d[b]  = 1'b1;
            ch_d[b]   = gnt_ch_s[b];
            rob_d[b]  = alloc_q[gnt_ch_s[b]][b];
            addr_d[b] = ch_req_addr_i[32'(gnt_ch_s[b])*AW +: AW];
            ptr_d[b]  = gnt_ch_s[b] + 2'd1;
         end else begin
            vld_d[b]  = vld_q[b] & ~bank_req_ready_i[b];
            ch_d[b]   = ch_q[b];
            rob_d[b]  = rob_q[b];
            addr_d[b] = addr_q[b];
            ptr_d[b]  = ptr_q[b];
         end
         for (int c = 0; c < NCH; c++) begin
            alloc_d[c][b] = alloc_q[c][b] + {2'b00, gnt_s[b][c]};
         end
      end
   end

   // Credit counters; a simultaneous grant and pop leaves a counter unchanged
   always_comb begin
      err_d = err_q;
      for (int c = 0; c < NCH; c++) begin
         for (int b = 0; b < NBK; b++) begin
`ifdef XBAR_ARB_CREDIT_CHK_EN
            if (gnt_s[b][c] && !ch_bank_pop_i[4*c+b]) begin
               if (outst_q[c][b] == 4'(ROB_DEPTH)) begin
                  err_d         = 1'b1;
                  outst_d[c][b] = outst_q[c][b];
               end else begin
                  outst_d[c][b] = outst_q[c][b] + 4'd1;
               end
            end else if (!gnt_s[b][c] && ch_bank_pop_i[4*c+b]) begin
               if (outst_q[c][b] == 4'd0) begin
                  err_d         = 1'b1;
                  outst_d[c][b] = outst_q[c][b];
               end else begin
                  outst_d[c][b] = outst_q[c][b] - 4'd1;
               end
            end else begin
               outst_d[c][b] = outst_q[c][b];
            end
`else
            outst_d[c][b] = outst_q[c][b] + {3'b000, gnt_s[b][c]} - {3'b000, ch_bank_pop_i[4*c+b]};
`endif
         end
`ifdef XBAR_ARB_CREDIT_CHK_EN
         if (ch_gnt_s[c] && !(|ch_bank_pop_i[4*c +: 4])) begin
            if (kof_q[c] == 5'(KOF_DEPTH)) begin
               err_d    = 1'b1;
               kof_d[c] = kof_q[c];
            end else begin
               kof_d[c] = kof_q[c] + 5'd1;
            end
         end else if (!ch_gnt_s[c] && (|ch_bank_pop_i[4*c +: 4])) begin
            if (kof_q[c] == 5'd0) begin
               err_d    = 1'b1;
               kof_d[c] = kof_q[c];
            end else begin
               kof_d[c] = kof_q[c] - 5'd1;
            end
         end else begin
            kof_d[c] = kof_q[c];
         end
`else
         kof_d[c] = kof_q[c] + {4'b0000, ch_gnt_s[c]} - {4'b0000, |ch_bank_pop_i[4*c +: 4]};
`endif
      end
   end

   // State registers; reset drops any pending output-stage request
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q <= 4'b0000;
         err_q <= 1'b0;
         for (int b = 0; b < NBK; b++) begin
            ptr_q[b]  <= 2'd0;
            ch_q[b]   <= 2'd0;
            rob_q[b]  <= 3'd0;
            addr_q[b] <= '0;
         end
         for (int c = 0; c < NCH; c++) begin
            kof_q[c] <= 5'd0;
            for (int b = 0; b < NBK; b++) begin
               alloc_q[c][b] <= 3'd0;
               outst_q[c][b] <= 4'd0;
            end
         end
      end else begin
         vld_q <= vld_d;
         err_q <= err_d;
         ptr_q <= ptr_d;
         ch_q  <= ch_d;
         rob_q <= rob_d;
         addr_q <= addr_d;
         kof_q <= kof_d;
         alloc_q <= alloc_d;
         outst_q <= outst_d;
      end
   end

   // Flatten the output stage onto the bank-side ports
   always_comb begin
      bank_req_valid_o = vld_q;
      for (int b = 0; b < NBK; b++) begin
         bank_req_ch_id_o[2*b +: 2]   = ch_q[b];
         bank_req_rob_num_o[3*b +: 3] = rob_q[b];
         bank_req_addr_o[b*AW +: AW]  = addr_q[b];
      end
   end

`ifdef XBAR_ARB_CREDIT_CHK_EN
   assign credit_err_o = err_q;
`else
   assign credit_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cross_bar_req_arb.sv
// Randomized scoreboard bench for cross_bar_req_arb against a transaction-level reference model.
`timescale 1ns/1ps
module tb_cross_bar_req_arb;
   localparam int AW = 32;
`ifdef XBAR_ARB_CREDIT_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b0;
   logic [3:0]      ch_req_valid_i = '0;
   logic [7:0]      ch_req_bank_id_i = '0;
   logic [4*AW-1:0] ch_req_addr_i = '0;
   logic [3:0]      ch_req_ready_o;
   logic [3:0]      bank_req_valid_o;
   logic [3:0]      bank_req_ready_i = '0;
   logic [7:0]      bank_req_ch_id_o;
   logic [11:0]     bank_req_rob_num_o;
   logic [4*AW-1:0] bank_req_addr_o;
   logic [3:0]      ch_kickoff_o;
   logic [7:0]      ch_kickoff_bank_id_o;
   logic [15:0]     ch_bank_pop_i = '0;
   logic            credit_err_o;

   always #5 clk_i = ~clk_i;

   cross_bar_req_arb #(.AW(AW), .ROB_DEPTH(8), .KOF_DEPTH(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ch_req_valid_i(ch_req_valid_i), .ch_req_bank_id_i(ch_req_bank_id_i),
      .ch_req_addr_i(ch_req_addr_i), .ch_req_ready_o(ch_req_ready_o),
      .bank_req_valid_o(bank_req_valid_o), .bank_req_ready_i(bank_req_ready_i),
      .bank_req_ch_id_o(bank_req_ch_id_o), .bank_req_rob_num_o(bank_req_rob_num_o),
      .bank_req_addr_o(bank_req_addr_o), .ch_kickoff_o(ch_kickoff_o),
      .ch_kickoff_bank_id_o(ch_kickoff_bank_id_o), .ch_bank_pop_i(ch_bank_pop_i),
      .credit_err_o(credit_err_o)
   );

   typedef struct {
      int            ch;
      int            rob;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t exp_q [4][$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Reference model: counts of credits, next tag per (ch,bank), next RR start per bank
   int   m_ptr   [4];
   int   m_alloc [4][4];
   int   m_outst [4][4];
   int   m_kof   [4];
   bit   m_full  [4];
   bit   m_err;
   bit   gnt_now [4];
   bit   mon_en = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_err = 1'b0;
      for (int b = 0; b < 4; b++) begin
         m_ptr[b] = 0; m_full[b] = 1'b0; gnt_now[b] = 1'b0;
         exp_q[b].delete();
         for (int c = 0; c < 4; c++) begin
            m_alloc[c][b] = 0; m_outst[c][b] = 0;
         end
      end
      for (int c = 0; c < 4; c++) m_kof[c] = 0;
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      @(negedge clk_i); #2;
      ch_req_valid_i = '0; ch_bank_pop_i = '0; bank_req_ready_i = '0;
      rst_i = 1'b1;
      #1;
      check("reset_bank_valid", 64'(bank_req_valid_o), 64'h0);
      check("reset_ready_kickoff", 64'({ch_req_ready_o, ch_kickoff_o, ch_kickoff_bank_id_o}), 64'h0);
      check("reset_fields", 64'({bank_req_ch_id_o, bank_req_rob_num_o}), 64'h0);
      check("reset_addr_err", 64'({bank_req_addr_o != '0, credit_err_o}), 64'h0);
      model_reset();
      @(negedge clk_i); #2;
      rst_i = 1'b0;
      mon_en = 1'b1;
   endtask

   // One clock of stimulus: drive, predict grant-cycle outputs, queue expected bank requests
   task automatic cycle(input logic [3:0] v, input logic [7:0] bid, input logic [4*AW-1:0] ad,
                        input logic [3:0] rdy, input logic [15:0] pop);
      logic [3:0] exp_rdy;
      logic [7:0] exp_bid;
      int         gch [4];
      bit         g, p, pc;
      exp_t       e;
      @(negedge clk_i); #2;
      ch_req_valid_i = v; ch_req_bank_id_i = bid; ch_req_addr_i = ad;
      bank_req_ready_i = rdy; ch_bank_pop_i = pop;
      #1;
      check("credit_err", 64'(credit_err_o), 64'(m_err));
      exp_rdy = 4'b0000; exp_bid = 8'h00;
      for (int b = 0; b < 4; b++) begin
         gch[b] = -1; gnt_now[b] = 1'b0;
         if (!m_full[b] || rdy[b]) begin
            for (int k = 0; k < 4; k++) begin
               int c = (m_ptr[b] + k) % 4;
               if (gch[b] < 0 && v[c] && int'(bid[2*c +: 2]) == b && m_outst[c][b] < 8 && m_kof[c] < 16)
                  gch[b] = c;
            end
         end
         if (gch[b] >= 0) begin
            exp_rdy[gch[b]] = 1'b1;
            exp_bid[2*gch[b] +: 2] = 2'(b);
         end
      end
      check("ch_req_ready", 64'(ch_req_ready_o), 64'(exp_rdy));
      check("ch_kickoff", 64'(ch_kickoff_o), 64'(exp_rdy));
      check("kickoff_bank_id", 64'(ch_kickoff_bank_id_o), 64'(exp_bid));
      for (int b = 0; b < 4; b++) begin
         if (gch[b] >= 0) begin
            e.ch = gch[b]; e.rob = m_alloc[gch[b]][b]; e.addr = ad[gch[b]*AW +: AW];
            exp_q[b].push_back(e);
            m_alloc[gch[b]][b] = (m_alloc[gch[b]][b] + 1) % 8;
            m_ptr[b] = (gch[b] + 1) % 4;
            m_full[b] = 1'b1;
            gnt_now[b] = 1'b1;
         end else if (rdy[b]) begin
            m_full[b] = 1'b0;
         end
      end
      for (int c = 0; c < 4; c++) begin
         for (int b = 0; b < 4; b++) begin
            g = (gch[b] == c); p = pop[4*c+b];
            if (CHK && p && !g && m_outst[c][b] == 0) m_err = 1'b1;
            else m_outst[c][b] = m_outst[c][b] + int'(g) - int'(p);
         end
         g = exp_rdy[c]; pc = |pop[4*c +: 4];
         if (CHK && pc && !g && m_kof[c] == 0) m_err = 1'b1;
         else m_kof[c] = m_kof[c] + int'(g) - int'(pc);
      end
   endtask

   // Monitor: compare whatever the output stage presents against the scoreboard
   always begin
      @(negedge clk_i); #4;
      if (mon_en && !rst_i) begin
         for (int b = 0; b < 4; b++) begin
            if (bank_req_valid_o[b]) begin
               if (exp_q[b].size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL bank_unexpected_valid: bank %0d got valid required idle", b);
               end else begin
                  check("bank_ch_id", 64'(bank_req_ch_id_o[2*b +: 2]), 64'(exp_q[b][0].ch));
                  check("bank_rob_num", 64'(bank_req_rob_num_o[3*b +: 3]), 64'(exp_q[b][0].rob));
                  check("bank_addr", 64'(bank_req_addr_o[b*AW +: AW]), 64'(exp_q[b][0].addr));
                  if (bank_req_ready_i[b]) void'(exp_q[b].pop_front());
               end
            end else begin
               check("bank_idle_queue", 64'(exp_q[b].size()), 64'(gnt_now[b] ? 1 : 0));
            end
         end
      end
   end

   function automatic logic [4*AW-1:0] rnd_addr();
      logic [4*AW-1:0] a;
      for (int c = 0; c < 4; c++) a[c*AW +: AW] = AW'($urandom);
      return a;
   endfunction

   function automatic logic [15:0] rnd_pop();
      logic [15:0] p;
      int          b;
      p = 16'h0000;
      for (int c = 0; c < 4; c++) begin
         b = $urandom_range(0, 3);
         if ($urandom_range(0, 2) == 0 && m_outst[c][b] > 0) p[4*c+b] = 1'b1;
      end
      return p;
   endfunction

   initial begin
      do_reset();
      // single request ch1 -> bank2 at 0x100
      cycle(4'b0010, 8'b0000_1000, {32'h0, 32'h0, 32'h100, 32'h0}, 4'hF, 16'h0);
      cycle(4'b0000, 8'h00, '0, 4'hF, 16'h0);
      // all channels contend for bank0
      for (int i = 0; i < 5; i++) cycle(4'hF, 8'h00, rnd_addr(), 4'hF, 16'h0);
      cycle(4'b0000, 8'h00, '0, 4'hF, 16'h0);
      // ch0 -> bank3 until ROB credit runs out, then one pop releases it
      for (int i = 0; i < 9; i++) cycle(4'b0001, 8'b0000_0011, rnd_addr(), 4'hF, 16'h0);
      cycle(4'b0001, 8'b0000_0011, rnd_addr(), 4'hF, 16'h0008);
      cycle(4'b0001, 8'b0000_0011, rnd_addr(), 4'hF, 16'h0);
      cycle(4'b0000, 8'h00, '0, 4'hF, 16'h0);
      // bank1 backpressure with ch2 streaming
      for (int i = 0; i < 6; i++) cycle(4'b0100, 8'b0001_0000, rnd_addr(), 4'b1101, 16'h0);
      cycle(4'b0100, 8'b0001_0000, rnd_addr(), 4'hF, 16'h0);
      cycle(4'b0000, 8'h00, '0, 4'hF, 16'h0);
      // four channels to four banks at once
      cycle(4'hF, 8'hE4, rnd_addr(), 4'hF, 16'h0);
      cycle(4'b0000, 8'h00, '0, 4'hF, 16'h0);
      // randomized traffic with a mid-run reset
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset();
         else cycle(4'($urandom), 8'($urandom), rnd_addr(),
                    ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF, rnd_pop());
      end
      for (int i = 0; i < 4; i++) cycle(4'b0000, 8'h00, '0, 4'hF, 16'h0);
      for (int b = 0; b < 4; b++) check("drain_empty", 64'(exp_q[b].size()), 64'h0);
`ifdef XBAR_ARB_CREDIT_CHK_EN
      do_reset();
      cycle(4'b0000, 8'h00, '0, 4'hF, 16'h0020);
      for (int i = 0; i < 4; i++) cycle(4'b0000, 8'h00, '0, 4'hF, 16'h0);
      check("credit_err_sticky", 64'(credit_err_o), 64'h1);
      do_reset();
      cycle(4'b0000, 8'h00, '0, 4'hF, 16'h0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
